uart_loader_ctrl: RTL and testbench



---
 rtl/uart_loader_ctrl_if.sv | 31 +++
 rtl/uart_loader_ctrl.sv | 89 ++++++++
 tb/tb_uart_loader_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_loader_ctrl_if.sv
// uart_loader_ctrl_if: UART byte input, load commands, memory write ports and core pass-through
interface uart_loader_ctrl_if #(
  parameter int IMEM_AW = 15,
  parameter int DMEM_AW = 17
);
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               load_data;
  logic               load_text;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [31:0]        dmem_wdata;
  logic               cpu_run;
  logic               cpu_rx_valid;
  logic [7:0]         cpu_rx_data;
  logic               busy;
  logic               err_overflow;
  modport master (
    output rx_valid, rx_data, load_data, load_text,
    input  imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata,
    input  cpu_run, cpu_rx_valid, cpu_rx_data, busy, err_overflow
  );
  modport slave (
    input  rx_valid, rx_data, load_data, load_text,
    output imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata,
    output cpu_run, cpu_rx_valid, cpu_rx_data, busy, err_overflow
  );
endinterface

// File: rtl/uart_loader_ctrl.sv
// uart_loader_ctrl: assembles big-endian UART words into imem/dmem, then releases the core and forwards bytes
module uart_loader_ctrl #(
  parameter int IMEM_AW = 15,
  parameter int DMEM_AW = 17
) (
  input  logic               clk,
  input  logic               rstn,
  uart_loader_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LEN, WORDS, RUN} state_t;
  state_t      state, state_nx;
  logic        tgt_text;
  logic [1:0]  bcnt;
  logic [23:0] shreg;
  logic [31:0] n;
  logic [31:0] wcnt;
  logic        wd_q;
  logic [31:0] word;
  logic        fin;
  logic        accept;
  logic        last_byte;
  logic        w_done;
  logic        fits;
  assign word      = {shreg, bus.rx_data};
  assign fin       = wd_q && wcnt == n;
  assign accept    = bus.rx_valid && (state == LEN || (state == WORDS && !fin));
  assign last_byte = accept && bcnt == 2'd3;
  assign w_done    = state == WORDS && last_byte;
  assign fits      = tgt_text ? ~|wcnt[31:IMEM_AW] : ~|wcnt[31:DMEM_AW];
  always_ff @(posedge clk)
    state <= !rstn ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.load_data || bus.load_text) state_nx = LEN;
      LEN:     if (last_byte) state_nx = word == 32'd0 ? (tgt_text ? RUN : IDLE) : WORDS;
      WORDS:   if (fin) state_nx = tgt_text ? RUN : IDLE;
      default: state_nx = state;
    endcase
  end
  always_comb begin
    bus.busy    = state == LEN || state == WORDS;
    bus.cpu_run = state == RUN;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tgt_text         <= 1'b0;
      bcnt             <= '0;
      shreg            <= '0;
      n                <= '0;
      wcnt             <= '0;
      wd_q             <= 1'b0;
      bus.imem_we      <= 1'b0;
      bus.imem_addr    <= '0;
      bus.imem_wdata   <= '0;
      bus.dmem_we      <= 1'b0;
      bus.dmem_addr    <= '0;
      bus.dmem_wdata   <= '0;
      bus.cpu_rx_valid <= 1'b0;
      bus.cpu_rx_data  <= '0;
      bus.err_overflow <= 1'b0;
    end else begin
      if (state == IDLE && (bus.load_data || bus.load_text)) tgt_text <= !bus.load_data;
      if (accept) begin
        bcnt  <= bcnt + 2'd1;
        shreg <= word[23:0];
      end
      if (state == LEN && last_byte) begin
        n    <= word;
        wcnt <= '0;
      end
      if (w_done) wcnt <= wcnt + 32'd1;
      wd_q        <= w_done;
      bus.imem_we <= w_done && tgt_text && fits;
      bus.dmem_we <= w_done && !tgt_text && fits;
      if (w_done && tgt_text && fits) begin
        bus.imem_addr  <= wcnt[IMEM_AW-1:0];
        bus.imem_wdata <= word;
      end
      if (w_done && !tgt_text && fits) begin
        bus.dmem_addr  <= wcnt[DMEM_AW-1:0];
        bus.dmem_wdata <= word;
      end
      if (w_done && !fits) bus.err_overflow <= 1'b1;
      bus.cpu_rx_valid <= state == RUN && bus.rx_valid;
      if (state == RUN && bus.rx_valid) bus.cpu_rx_data <= bus.rx_data;
    end
  end
endmodule

// File: tb/tb_uart_loader_ctrl.sv
// tb_uart_loader_ctrl: directed self-checking bench for uart_loader_ctrl
module tb_uart_loader_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  int viol = 0;
  int rx_cnt = 0;
  logic [63:0] iq[$];
  logic [63:0] dq[$];
  always #5 clk = ~clk;
  uart_loader_ctrl_if #(.IMEM_AW(2), .DMEM_AW(17)) bus ();
  uart_loader_ctrl #(.IMEM_AW(2), .DMEM_AW(17)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always @(negedge clk) begin
    if (bus.imem_we) iq.push_back({30'd0, bus.imem_addr, bus.imem_wdata});
    if (bus.dmem_we) dq.push_back({15'd0, bus.dmem_addr, bus.dmem_wdata});
    if ((bus.imem_we && bus.dmem_we) || ((bus.imem_we || bus.dmem_we) && !bus.busy) || (bus.cpu_rx_valid && !bus.cpu_run)) viol++;
    if (bus.cpu_rx_valid) rx_cnt++;
  end
  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic idle(int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic send_byte(logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic send_word(logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask
  task automatic pulse(logic d, logic t);
    bus.load_data = d;
    bus.load_text = t;
    @(negedge clk);
    bus.load_data = 1'b0;
    bus.load_text = 1'b0;
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask
  task automatic check_zero(string tag);
    check({tag, "_mem"}, {bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}, '0);
    check({tag, "_ctl"}, {bus.cpu_run, bus.cpu_rx_valid, bus.cpu_rx_data, bus.busy, bus.err_overflow}, '0);
  endtask
  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.load_data = 1'b0;
    bus.load_text = 1'b0;
    idle(2);
    check_zero("reset");
    rstn = 1'b1;
    send_byte(8'h55);
    idle(2);
    check("stray_busy", bus.busy, 1'b0);
    check("stray_wr", iq.size() + dq.size(), 0);
    pulse(1'b1, 1'b0);
    check("dl_busy", bus.busy, 1'b1);
    send_word(32'd2);
    send_word(32'h11223344);
    check("dl_w0", {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}, {1'b1, 17'd0, 32'h11223344});
    send_word(32'hAABBCCDD);
    check("dl_w1", {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, bus.busy}, {1'b1, 17'd1, 32'hAABBCCDD, 1'b1});
    idle(1);
    check("dl_exit", {bus.busy, bus.cpu_run, bus.dmem_we}, 3'b000);
    check("dl_cnt", {dq.size(), iq.size()}, {32'd2, 32'd0});
    check("dl_q0", dq[0], {15'd0, 17'd0, 32'h11223344});
    pulse(1'b1, 1'b1);
    send_word(32'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    pulse(1'b0, 1'b1);
    send_byte(8'h03);
    send_byte(8'h04);
    check("sim_wr", {bus.dmem_we, bus.imem_we, bus.dmem_addr, bus.dmem_wdata}, {2'b10, 17'd0, 32'h01020304});
    idle(1);
    check("sim_exit", {bus.busy, bus.cpu_run}, 2'b00);
    check("sim_cnt", {dq.size(), iq.size()}, {32'd3, 32'd0});
    pulse(1'b1, 1'b0);
    send_word(32'd1);
    send_byte(8'hFF);
    send_byte(8'hEE);
    rstn = 1'b0;
    @(negedge clk);
    check_zero("rst_mid");
    rstn = 1'b1;
    pulse(1'b1, 1'b0);
    send_word(32'd1);
    send_word(32'h12345678);
    check("rst_fresh", {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}, {1'b1, 17'd0, 32'h12345678});
    idle(1);
    check("rst_exit", {bus.busy, bus.cpu_run, 32'(dq.size())}, {2'b00, 32'd4});
    pulse(1'b0, 1'b1);
    send_word(32'd1);
    send_word(32'hDEADBEEF);
    check("tx_wr", {bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.cpu_run}, {1'b1, 2'd0, 32'hDEADBEEF, 1'b0});
    idle(1);
    check("tx_run", {bus.cpu_run, bus.imem_we, bus.busy}, 3'b100);
    send_byte(8'h41);
    check("rx_41", {bus.cpu_rx_valid, bus.cpu_rx_data}, {1'b1, 8'h41});
    send_byte(8'h42);
    check("rx_42", {bus.cpu_rx_valid, bus.cpu_rx_data}, {1'b1, 8'h42});
    send_byte(8'h43);
    check("rx_43", {bus.cpu_rx_valid, bus.cpu_rx_data}, {1'b1, 8'h43});
    idle(1);
    check("rx_idle", bus.cpu_rx_valid, 1'b0);
    pulse(1'b1, 1'b0);
    idle(1);
    check("run_cmd", {bus.cpu_run, bus.busy}, 2'b10);
    check("rx_cnt", {rx_cnt, iq.size(), dq.size()}, {32'd3, 32'd1, 32'd4});
    do_reset();
    check("zl_rst", bus.cpu_run, 1'b0);
    pulse(1'b0, 1'b1);
    send_word(32'd0);
    check("zl_run", {bus.cpu_run, bus.busy, bus.imem_we}, 3'b100);
    idle(1);
    check("zl_cnt", iq.size(), 1);
    do_reset();
    pulse(1'b0, 1'b1);
    send_word(32'd5);
    for (int i = 0; i < 5; i++) begin
      send_word(32'hA0000000 + 32'(i));
      if (i == 3) check("ov_w3", {bus.imem_we, bus.imem_addr, bus.err_overflow}, {1'b1, 2'd3, 1'b0});
    end
    check("ov_w4", {bus.err_overflow, bus.imem_we, bus.cpu_run}, 3'b100);
    idle(1);
    check("ov_run", {bus.cpu_run, bus.err_overflow, bus.busy}, 3'b110);
    check("ov_cnt", iq.size(), 5);
    check("ov_q1", iq[1], {30'd0, 2'd0, 32'hA0000000});
    check("ov_q4", iq[4], {30'd0, 2'd3, 32'hA0000003});
    do_reset();
    check("ov_clr", {bus.err_overflow, bus.cpu_run}, 2'b00);
    check("viol", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
